pkt_read_sched: RTL and testbench

Sequences read-out of the captured ADC sample buffer into fixed-length packets on the ADC_DATA/ADC_DATA_VALID pad path. It sits in u_pktctrl_top between the capture SRAM read port and the pad output register, and takes its configuration from the top regfile: clock enable, soft reset, start/again strobes, gap, data-length code, idle length and packet count. It generates SRAM read addresses, paces output words, inserts inter-packet idle time and reports progress.

---
 rtl/pkt_sched_pkg.sv | 33 +++
 rtl/pkt_wait_cnt.sv | 29 ++
 rtl/pkt_read_sched.sv | 200 ++++++++++++++++++++
 tb/tb_pkt_read_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packet read-out scheduler.
package pkt_sched_pkg;

    // Cycles from an SRAM read strobe to the matching registered output word.
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        LEN_216  = 2'b00,
        LEN_432  = 2'b01,
        LEN_864  = 2'b10,
        LEN_1728 = 2'b11
    } len_code_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        PACE = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic logic [10:0] len_words(input len_code_e code);
        logic [10:0] n;
        case (code)
            LEN_216:  n = 11'd216;
            LEN_432:  n = 11'd432;
            LEN_864:  n = 11'd864;
            default:  n = 11'd1728;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pkt_wait_cnt.sv
// Loadable 8-bit down-counter shared by the PACE and GAP waits.
// o_expired is high once the count has reached 1 (or 0).
module pkt_wait_cnt (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_expired
);

    logic [7:0] r_cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_expired = (r_cnt <= 8'd1);

endmodule

// File: rtl/pkt_read_sched.sv
// Packet read-out scheduler: walks the capture SRAM linearly, paces words,
// inserts idle time between packets and presents data two cycles after each read.
// Optional build macro PKT_SELF_TEST_EN adds self_test_mode, which replaces
// SRAM data with a {pkt_cnt, word_idx} pattern.
//
// state | meaning
// IDLE  | waiting for start/again
// DATA  | one SRAM read issued this cycle
// PACE  | inter-word spacing inside a packet
// GAP   | idle time between packets
// DONE  | one-cycle end-of-run pulse
module pkt_read_sched
    import pkt_sched_pkg::*;
#(
    parameter int DW  = 18,
    parameter int AW  = 16,
    parameter int PNW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clk_en,
    input  logic           sw_rstn,
    input  logic           capture_start,
    input  logic           capture_again,
    input  logic [7:0]     cfg_gap,
    input  logic [1:0]     cfg_data_length,
    input  logic [7:0]     cfg_idle_length,
    input  logic [PNW-1:0] cfg_pkt_num,
`ifdef PKT_SELF_TEST_EN
    input  logic           self_test_mode,
`endif
    output logic           mem_rd_en,
    output logic [AW-1:0]  mem_rd_addr,
    input  logic [DW-1:0]  mem_rd_data,
    output logic [DW-1:0]  adc_data,
    output logic           adc_data_valid,
    output logic           busy,
    output logic           done,
    output logic [PNW-1:0] pkt_cnt
);

    state_e             r_state;
    state_e             w_next_state;
    logic [7:0]         r_gap;
    logic [7:0]         r_idle;
    logic [10:0]        r_len;
    logic [PNW-1:0]     r_pkt_num;
    logic [AW-1:0]      r_addr;
    logic [10:0]        r_word_idx;
    logic [PNW-1:0]     r_pkt_cnt;
    logic               r_busy;
    logic [RD_LAT-1:0]  r_vld_sr;
    logic [DW-1:0]      r_adc_data;

    logic               w_rst_n;
    logic               w_accept;
    logic               w_last_word;
    logic [PNW-1:0]     w_pkt_inc;
    logic               w_rd_en;
    logic               w_load;
    logic [7:0]         w_load_val;
    logic               w_expired;
    logic [DW-1:0]      w_src_data;

    assign w_rst_n     = rstn & sw_rstn;
    assign w_last_word = (r_word_idx == (r_len - 11'd1));
    assign w_pkt_inc   = r_pkt_cnt + {{(PNW-1){1'b0}}, 1'b1};
    // Read strobe is gated by clk_en so a frozen block never advances the SRAM
    // output; the in-flight word stays on mem_rd_data until the block resumes.
    assign w_rd_en     = (r_state == DATA) && clk_en;

    pkt_wait_cnt u_wait_cnt (
        .i_clk      (clk),
        .i_rstn     (w_rst_n),
        .i_en       (clk_en),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // Next-state decode and wait-counter loading.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_load_val   = 8'd0;
        case (r_state)
            IDLE: begin
                if (capture_start || capture_again) begin
                    w_accept     = 1'b1;
                    w_next_state = (cfg_pkt_num == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (w_last_word) begin
                    if (w_pkt_inc == r_pkt_num) begin
                        w_next_state = DONE;
                    end else if (r_idle != 8'd0) begin
                        w_next_state = GAP;
                        w_load       = 1'b1;
                        w_load_val   = r_idle;
                    end else begin
                        w_next_state = DATA;
                    end
                end else if (r_gap != 8'd0) begin
                    w_next_state = PACE;
                    w_load       = 1'b1;
                    w_load_val   = r_gap;
                end else begin
                    w_next_state = DATA;
                end
            end
            PACE, GAP: begin
                if (w_expired) begin
                    w_next_state = DATA;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, latched configuration and run counters.
    always_ff @(posedge clk) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_gap      <= 8'd0;
            r_idle     <= 8'd0;
            r_len      <= 11'd0;
            r_pkt_num  <= '0;
            r_addr     <= '0;
            r_word_idx <= 11'd0;
            r_pkt_cnt  <= '0;
            r_busy     <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_gap      <= cfg_gap;
                r_idle     <= cfg_idle_length;
                r_len      <= len_words(len_code_e'(cfg_data_length));
                r_pkt_num  <= cfg_pkt_num;
                r_addr     <= '0;
                r_word_idx <= 11'd0;
                r_pkt_cnt  <= '0;
                r_busy     <= 1'b1;
            end
            if (r_state == DATA) begin
                r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
                if (w_last_word) begin
                    r_word_idx <= 11'd0;
                    r_pkt_cnt  <= w_pkt_inc;
                end else begin
                    r_word_idx <= r_word_idx + 11'd1;
                end
            end
            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef PKT_SELF_TEST_EN
    logic [DW-1:0] r_st_word;

    // Pattern word tracks the read it replaces, one stage behind the strobe.
    always_ff @(posedge clk) begin
        if (!w_rst_n) begin
            r_st_word <= '0;
        end else if (clk_en && w_rd_en) begin
            r_st_word <= {r_pkt_cnt[DW-12:0], r_word_idx};
        end
    end

    assign w_src_data = self_test_mode ? r_st_word : mem_rd_data;
`else
    assign w_src_data = mem_rd_data;
`endif

    // Output pipeline: valid follows the read strobe, data held when not valid.
    always_ff @(posedge clk) begin
        if (!w_rst_n) begin
            r_vld_sr   <= '0;
            r_adc_data <= '0;
        end else if (clk_en) begin
            r_vld_sr <= {r_vld_sr[RD_LAT-2:0], w_rd_en};
            if (r_vld_sr[RD_LAT-2]) begin
                r_adc_data <= w_src_data;
            end
        end
    end

    assign mem_rd_en      = w_rd_en;
    assign mem_rd_addr    = r_addr;
    assign adc_data       = r_adc_data;
    assign adc_data_valid = r_vld_sr[RD_LAT-1];
    assign busy           = r_busy;
    assign done           = (r_state == DONE);
    assign pkt_cnt        = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_read_sched.sv
// Directed bench for pkt_read_sched with a one-cycle-latency SRAM model.
module tb_pkt_read_sched;

    localparam int DW  = 18;
    localparam int AW  = 16;
    localparam int PNW = 16;

    logic           clk;
    logic           rstn;
    logic           clk_en;
    logic           sw_rstn;
    logic           capture_start;
    logic           capture_again;
    logic [7:0]     cfg_gap;
    logic [1:0]     cfg_data_length;
    logic [7:0]     cfg_idle_length;
    logic [PNW-1:0] cfg_pkt_num;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    logic [DW-1:0]  mem_rd_data;
    logic [DW-1:0]  adc_data;
    logic           adc_data_valid;
    logic           busy;
    logic           done;
    logic [PNW-1:0] pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pkt_read_sched #(.DW(DW), .AW(AW), .PNW(PNW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .clk_en          (clk_en),
        .sw_rstn         (sw_rstn),
        .capture_start   (capture_start),
        .capture_again   (capture_again),
        .cfg_gap         (cfg_gap),
        .cfg_data_length (cfg_data_length),
        .cfg_idle_length (cfg_idle_length),
        .cfg_pkt_num     (cfg_pkt_num),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .adc_data        (adc_data),
        .adc_data_valid  (adc_data_valid),
        .busy            (busy),
        .done            (done),
        .pkt_cnt         (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_at(input int addr);
        logic [15:0] a;
        a = addr[15:0];
        return {2'b01, a ^ 16'h5A5A};
    endfunction

    // SRAM model: registered read, output holds when not strobed.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {2'b01, mem_rd_addr ^ 16'h5A5A};
    end

    // Monitor state
    int   cyc = 0;
    logic en_q = 1'b0;
    int   mon_reads, mon_words, mon_bad, mon_dones;
    int   mon_last_addr, mon_first_rd, mon_first_v, mon_last_v;
    int   mon_n1, mon_n9, mon_maxi;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        en_q <= clk_en;
    end

    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mon_reads++;
            mon_last_addr = int'(mem_rd_addr);
            if (mon_first_rd < 0) mon_first_rd = cyc;
        end
        if (en_q) begin
            if (done === 1'b1) mon_dones++;
            if (adc_data_valid === 1'b1) begin
                if (adc_data !== word_at(mon_words)) mon_bad++;
                mon_words++;
                if (mon_first_v < 0) begin
                    mon_first_v = cyc;
                end else begin
                    if (cyc - mon_last_v == 1) mon_n1++;
                    if (cyc - mon_last_v == 9) mon_n9++;
                    if (cyc - mon_last_v > mon_maxi) mon_maxi = cyc - mon_last_v;
                end
                mon_last_v = cyc;
            end
        end
    end

    task automatic clear_mon();
        mon_reads = 0; mon_words = 0; mon_bad = 0; mon_dones = 0;
        mon_last_addr = -1; mon_first_rd = -1; mon_first_v = -1; mon_last_v = 0;
        mon_n1 = 0; mon_n9 = 0; mon_maxi = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
    endtask

    task automatic pulse_again();
        capture_again = 1'b1;
        tick();
        capture_again = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] gap, input logic [1:0] len,
                           input logic [7:0] idle, input logic [PNW-1:0] num);
        cfg_gap = gap; cfg_data_length = len; cfg_idle_length = idle; cfg_pkt_num = num;
    endtask

    // Waits for the done pulse, checks its shape and lets the output tail drain.
    task automatic wait_done(input int budget, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        if (got == 1) begin
            check({tag, "_busy_at_done"}, busy, 1);
            tick();
            check({tag, "_done_single"}, done, 0);
            check({tag, "_busy_after"}, busy, 0);
        end
        repeat (3) tick();
    endtask

    initial begin
        rstn = 1'b0; sw_rstn = 1'b1; clk_en = 1'b1;
        capture_start = 1'b0; capture_again = 1'b0;
        set_cfg(8'd0, 2'b00, 8'd0, 16'd0);
        clear_mon();
        repeat (3) tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", adc_data_valid, 0);
        check("rst_data", adc_data, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        rstn = 1'b1;
        tick();

        // Two 216-word packets, no pacing, 15 idle cycles between
        set_cfg(8'd0, 2'b00, 8'd15, 16'd2);
        clear_mon();
        pulse_start();
        check("r1_busy_on", busy, 1);
        wait_done(2000, "r1");
        check("r1_words", mon_words, 432);
        check("r1_reads", mon_reads, 432);
        check("r1_data", mon_bad, 0);
        check("r1_last_addr", mon_last_addr, 431);
        check("r1_pkt_cnt", pkt_cnt, 2);
        check("r1_dones", mon_dones, 1);
        check("r1_latency", mon_first_v - mon_first_rd, 2);
        check("r1_contig", mon_n1, 430);
        check("r1_gap_len", mon_maxi, 16);

        // Paced run; config changed after start must be ignored
        set_cfg(8'd8, 2'b01, 8'd5, 16'd1);
        clear_mon();
        pulse_start();
        set_cfg(8'd0, 2'b11, 8'd0, 16'd5);
        wait_done(5000, "r2");
        check("r2_words", mon_words, 432);
        check("r2_data", mon_bad, 0);
        check("r2_last_addr", mon_last_addr, 431);
        check("r2_latency", mon_first_v - mon_first_rd, 2);
        check("r2_every9", mon_n9, 431);
        check("r2_pkt_cnt", pkt_cnt, 1);

        // Zero packets: done on the cycle after acceptance, no reads
        set_cfg(8'd0, 2'b00, 8'd0, 16'd0);
        clear_mon();
        pulse_start();
        check("r3_done", done, 1);
        check("r3_busy", busy, 1);
        tick();
        check("r3_done_off", done, 0);
        check("r3_busy_off", busy, 0);
        repeat (3) tick();
        check("r3_reads", mon_reads, 0);
        check("r3_pkt_cnt", pkt_cnt, 0);

        // Mid-run strobes and a clk_en freeze
        set_cfg(8'd2, 2'b00, 8'd3, 16'd2);
        clear_mon();
        pulse_start();
        repeat (50) tick();
        capture_start = 1'b1; capture_again = 1'b1;
        tick();
        capture_start = 1'b0; capture_again = 1'b0;
        repeat (20) tick();
        clk_en = 1'b0;
        pulse_again();
        repeat (9) tick();
        check("r4_busy_frozen", busy, 1);
        clk_en = 1'b1;
        wait_done(3000, "r4");
        check("r4_words", mon_words, 432);
        check("r4_reads", mon_reads, 432);
        check("r4_data", mon_bad, 0);
        check("r4_last_addr", mon_last_addr, 431);
        check("r4_pkt_cnt", pkt_cnt, 2);
        check("r4_dones", mon_dones, 1);

        // Start pulse while frozen in IDLE is lost
        clear_mon();
        clk_en = 1'b0;
        pulse_start();
        tick();
        clk_en = 1'b1;
        repeat (5) tick();
        check("r4_lost_busy", busy, 0);
        check("r4_lost_reads", mon_reads, 0);

        // Replay via again with longest packets
        set_cfg(8'd0, 2'b11, 8'd0, 16'd3);
        clear_mon();
        pulse_again();
        check("r5_busy_on", busy, 1);
        wait_done(7000, "r5");
        check("r5_words", mon_words, 5184);
        check("r5_data", mon_bad, 0);
        check("r5_last_addr", mon_last_addr, 5183);
        check("r5_contig", mon_n1, 5183);
        check("r5_pkt_cnt", pkt_cnt, 3);

        // Soft reset mid-packet, then a clean run
        set_cfg(8'd0, 2'b00, 8'd0, 16'd1);
        clear_mon();
        pulse_start();
        repeat (100) tick();
        sw_rstn = 1'b0;
        tick();
        check("r6_busy", busy, 0);
        check("r6_valid", adc_data_valid, 0);
        check("r6_data", adc_data, 0);
        check("r6_rd_en", mem_rd_en, 0);
        check("r6_addr", mem_rd_addr, 0);
        check("r6_pkt_cnt", pkt_cnt, 0);
        check("r6_done", done, 0);
        sw_rstn = 1'b1;
        repeat (5) tick();
        check("r6_no_done", mon_dones, 0);
        clear_mon();
        pulse_start();
        wait_done(500, "r6b");
        check("r6b_words", mon_words, 216);
        check("r6b_data", mon_bad, 0);
        check("r6b_dones", mon_dones, 1);
        check("r6b_pkt_cnt", pkt_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
